ibex_fetch_req_ctrl: RTL and testbench

IBEX_FETCH_REQ_CTRL -- requirements
Module: ibex_fetch_req_ctrl

---
 rtl/ibex_fetch_req_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request controller: issues word fetches to memory,
// tracks granted-but-unanswered requests and pushes in-order responses into
// the fetch FIFO, discarding responses made stale by a branch redirect.
module ibex_fetch_req_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] addr_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        fifo_ready_i,
   output logic        fifo_valid_o,
   output logic [31:0] fifo_addr_o,
   output logic [31:0] fifo_rdata_o,
   output logic        fifo_clear_o,
   output logic        busy_o
);

   typedef enum logic {
      IDLE,
      WAIT_GNT
   } state_e;

   localparam logic [1:0]  MAX_CNT   = 2'(MAX_OUTSTANDING);
   localparam logic [31:0] BOOT_WORD = BOOT_ADDR & 32'hFFFF_FFFC;

   state_e      state_q, state_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] wait_addr_q, wait_addr_d;
   logic [1:0]  out_cnt_q, out_cnt_d;
   logic [1:0]  discard_cnt_q, discard_cnt_d;
   logic        stale_pending_q, stale_pending_d;
   logic [31:0] queue_q [2];
   logic [31:0] queue_d [2];

   logic        issue_ok;
   logic        grant;
   logic        pop;
   logic        push_idx;
   logic [31:0] req_addr;
   logic [31:0] branch_target;

   // Request side: decide whether to present a request, which address it
   // carries (held copy while waiting for grant), and the FSM next state.
   always_comb begin
      state_d       = state_q;
      wait_addr_d   = wait_addr_q;
      branch_target = addr_i & 32'hFFFF_FFFC;
      issue_ok      = req_i & fifo_ready_i & (out_cnt_q < MAX_CNT) & ~branch_i;
      req_addr      = (state_q == WAIT_GNT) ? wait_addr_q : fetch_addr_q;
      instr_req_o   = ~rst_i & ((state_q == WAIT_GNT) | issue_ok);
      instr_addr_o  = req_addr;
      grant         = instr_req_o & instr_gnt_i;
      unique case (state_q)
         IDLE: begin
            wait_addr_d = fetch_addr_q;
            if (issue_ok && !instr_gnt_i) begin
               state_d = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            if (instr_gnt_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bookkeeping: outstanding count, address queue, fetch pointer and the
   // discard/stale tracking that drops responses older than a redirect.
   always_comb begin
      pop             = instr_rvalid_i & (out_cnt_q != 2'd0);
      out_cnt_d       = out_cnt_q;
      discard_cnt_d   = discard_cnt_q;
      stale_pending_d = stale_pending_q;
      fetch_addr_d    = fetch_addr_q;
      queue_d         = queue_q;
      push_idx        = (out_cnt_q == 2'd2) || ((out_cnt_q == 2'd1) && !pop);

      if (grant && !pop) begin
         out_cnt_d = out_cnt_q + 2'd1;
      end else if (pop && !grant) begin
         out_cnt_d = out_cnt_q - 2'd1;
      end

      if (pop) begin
         queue_d[0] = queue_q[1];
      end
      if (grant) begin
         queue_d[push_idx] = req_addr;
      end

      if (pop && discard_cnt_q != 2'd0) begin
         discard_cnt_d = discard_cnt_q - 2'd1;
      end
      if (grant && stale_pending_q) begin
         discard_cnt_d = discard_cnt_d + 2'd1;
      end

      if (grant) begin
         stale_pending_d = 1'b0;
         if (!stale_pending_q) begin
            fetch_addr_d = req_addr + 32'd4;
         end
      end

      if (branch_i) begin
         fetch_addr_d  = branch_target;
         discard_cnt_d = out_cnt_d;
         if (state_q == WAIT_GNT && !grant) begin
            stale_pending_d = 1'b1;
         end
      end
   end

   // Response side: forward live responses to the FIFO, flush on redirect.
   always_comb begin
      fifo_valid_o = ~rst_i & pop & (discard_cnt_q == 2'd0) & ~branch_i;
      fifo_addr_o  = fifo_valid_o ? queue_q[0] : 32'd0;
      fifo_rdata_o = fifo_valid_o ? instr_rdata_i : 32'd0;
      fifo_clear_o = ~rst_i & branch_i;
      busy_o       = ~rst_i & ((out_cnt_q != 2'd0) | (state_q == WAIT_GNT));
   end

   // State registers with asynchronous reset back to the boot fetch point.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         fetch_addr_q    <= BOOT_WORD;
         wait_addr_q     <= BOOT_WORD;
         out_cnt_q       <= 2'd0;
         discard_cnt_q   <= 2'd0;
         stale_pending_q <= 1'b0;
         queue_q[0]      <= 32'd0;
         queue_q[1]      <= 32'd0;
      end else begin
         state_q         <= state_d;
         fetch_addr_q    <= fetch_addr_d;
         wait_addr_q     <= wait_addr_d;
         out_cnt_q       <= out_cnt_d;
         discard_cnt_q   <= discard_cnt_d;
         stale_pending_q <= stale_pending_d;
         queue_q[0]      <= queue_d[0];
         queue_q[1]      <= queue_d[1];
      end
   end

   // A response with nothing outstanding means the memory side is broken.
   assert property (@(posedge clk_i) disable iff (rst_i)
                    !(instr_rvalid_i && out_cnt_q == 2'd0));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Testbench for ibex_fetch_req_ctrl: directed cycle-by-cycle vectors.
// Expected FIFO pushes go into a scoreboard queue when the response is
// driven; an independent monitor pops and compares on every fifo_valid_o.
module tb_ibex_fetch_req_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        branch_i;
   logic [31:0] addr_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        fifo_ready_i;
   logic        fifo_valid_o;
   logic [31:0] fifo_addr_o;
   logic [31:0] fifo_rdata_o;
   logic        fifo_clear_o;
   logic        busy_o;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [31:0] expAddrQ [$];
   logic [31:0] expDataQ [$];

   ibex_fetch_req_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .addr_i         (addr_i),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .fifo_ready_i   (fifo_ready_i),
      .fifo_valid_o   (fifo_valid_o),
      .fifo_addr_o    (fifo_addr_o),
      .fifo_rdata_o   (fifo_rdata_o),
      .fifo_clear_o   (fifo_clear_o),
      .busy_o         (busy_o)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk_i = ~clk_i;

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   // Record a FIFO push the DUT must make for the response about to be driven.
   task automatic expectPush(input logic [31:0] a, input logic [31:0] d);
      expAddrQ.push_back(a);
      expDataQ.push_back(d);
   endtask

   // Drive one cycle of inputs just after the rising edge, then wait for the
   // falling edge so combinational outputs can be checked mid-cycle.
   task automatic applyStimulus(input logic req, input logic br,
                                input logic [31:0] baddr, input logic gnt,
                                input logic rv, input logic [31:0] rd,
                                input logic rdy);
      @(posedge clk_i);
      #1;
      req_i          = req;
      branch_i       = br;
      addr_i         = baddr;
      instr_gnt_i    = gnt;
      instr_rvalid_i = rv;
      instr_rdata_i  = rd;
      fifo_ready_i   = rdy;
      @(negedge clk_i);
   endtask

   // Idle cycle: nothing requested, FIFO ready.
   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
   endtask

   // Assert reset with busy-looking inputs and check every output is quiet.
   task automatic doReset();
      @(posedge clk_i);
      #1;
      rst_i          = 1'b1;
      req_i          = 1'b1;
      branch_i       = 1'b1;
      addr_i         = 32'h5555_5554;
      instr_gnt_i    = 1'b1;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h1234_5678;
      fifo_ready_i   = 1'b1;
      @(negedge clk_i);
      checkOutput("rst_instr_req", instr_req_o, 32'd0);
      checkOutput("rst_instr_addr", instr_addr_o, 32'h0000_0080);
      checkOutput("rst_fifo_valid", fifo_valid_o, 32'd0);
      checkOutput("rst_fifo_addr", fifo_addr_o, 32'd0);
      checkOutput("rst_fifo_clear", fifo_clear_o, 32'd0);
      checkOutput("rst_busy", busy_o, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i          = 1'b0;
      req_i          = 1'b0;
      branch_i       = 1'b0;
      addr_i         = 32'd0;
      instr_gnt_i    = 1'b0;
      instr_rdata_i  = 32'd0;
   endtask

   // Scoreboard monitor: every push must match the oldest expectation.
   initial begin
      logic [31:0] ea;
      logic [31:0] ed;
      forever begin
         @(negedge clk_i);
         if (!rst_i && fifo_valid_o) begin
            if (expAddrQ.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL unexpected_push: got addr %h, required no push", fifo_addr_o);
            end else begin
               ea = expAddrQ.pop_front();
               ed = expDataQ.pop_front();
               checkOutput("push_addr", fifo_addr_o, ea);
               checkOutput("push_data", fifo_rdata_o, ed);
            end
         end
      end
   end

   // Directed scenarios, each starting from a fresh reset.
   initial begin
      rst_i          = 1'b1;
      req_i          = 1'b0;
      branch_i       = 1'b0;
      addr_i         = 32'd0;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'd0;
      fifo_ready_i   = 1'b0;

      // Back-to-back fetch from boot address with immediate grants.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("A_req0", instr_req_o, 32'd1);
      checkOutput("A_addr0", instr_addr_o, 32'h80);
      expectPush(32'h80, 32'hA000_0080);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA000_0080, 1'b1);
      checkOutput("A_req1", instr_req_o, 32'd1);
      checkOutput("A_addr1", instr_addr_o, 32'h84);
      expectPush(32'h84, 32'hA000_0084);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000_0084, 1'b1);
      checkOutput("A_busy_inflight", busy_o, 32'd1);
      checkOutput("A_req_off", instr_req_o, 32'd0);
      idleCycle();
      checkOutput("A_busy_done", busy_o, 32'd0);
      checkOutput("A_next_addr", instr_addr_o, 32'h88);

      // Grant withheld three cycles while req_i and fifo_ready_i drop.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("B_req_w0", instr_req_o, 32'd1);
      checkOutput("B_addr_w0", instr_addr_o, 32'h80);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
         checkOutput("B_req_hold", instr_req_o, 32'd1);
         checkOutput("B_addr_hold", instr_addr_o, 32'h80);
         checkOutput("B_busy_hold", busy_o, 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput("B_req_gnt", instr_req_o, 32'd1);
      checkOutput("B_addr_gnt", instr_addr_o, 32'h80);
      expectPush(32'h80, 32'hB000_0080);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hB000_0080, 1'b1);
      checkOutput("B_req_after", instr_req_o, 32'd0);
      checkOutput("B_addr_after", instr_addr_o, 32'h84);
      idleCycle();
      checkOutput("B_busy_done", busy_o, 32'd0);

      // Branch with two outstanding: both responses dropped, target fetched.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("C_addr1", instr_addr_o, 32'h84);
      applyStimulus(1'b1, 1'b1, 32'h1002, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("C_clear", fifo_clear_o, 32'd1);
      checkOutput("C_req_branch", instr_req_o, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hC000_0080, 1'b1);
      checkOutput("C_req_full", instr_req_o, 32'd0);
      checkOutput("C_drop0", fifo_valid_o, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'hC000_0084, 1'b1);
      checkOutput("C_req_target", instr_req_o, 32'd1);
      checkOutput("C_addr_target", instr_addr_o, 32'h1000);
      checkOutput("C_drop1", fifo_valid_o, 32'd0);
      expectPush(32'h1000, 32'hC000_1000);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hC000_1000, 1'b1);
      checkOutput("C_clear_off", fifo_clear_o, 32'd0);
      idleCycle();
      checkOutput("C_busy_done", busy_o, 32'd0);
      checkOutput("C_next_addr", instr_addr_o, 32'h1004);

      // Branch while 0x88 waits for grant: 0x88 data dropped, target next.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      expectPush(32'h80, 32'hD000_0080);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'hD000_0080, 1'b1);
      expectPush(32'h84, 32'hD000_0084);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hD000_0084, 1'b1);
      checkOutput("D_req88", instr_req_o, 32'd1);
      checkOutput("D_addr88", instr_addr_o, 32'h88);
      applyStimulus(1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("D_req_hold_br", instr_req_o, 32'd1);
      checkOutput("D_addr_hold_br", instr_addr_o, 32'h88);
      checkOutput("D_clear", fifo_clear_o, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("D_addr_stale_gnt", instr_addr_o, 32'h88);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'hDEAD_0088, 1'b1);
      checkOutput("D_req_target", instr_req_o, 32'd1);
      checkOutput("D_addr_target", instr_addr_o, 32'h2000);
      checkOutput("D_drop88", fifo_valid_o, 32'd0);
      expectPush(32'h2000, 32'hD000_2000);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hD000_2000, 1'b1);
      idleCycle();
      checkOutput("D_busy_done", busy_o, 32'd0);
      checkOutput("D_next_addr", instr_addr_o, 32'h2004);

      // Outstanding limit and fifo_ready_i gating; grant+response same cycle.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("E_req_notready", instr_req_o, 32'd0);
      checkOutput("E_busy", busy_o, 32'd1);
      expectPush(32'h80, 32'hE000_0080);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hE000_0080, 1'b1);
      checkOutput("E_req_max", instr_req_o, 32'd0);
      expectPush(32'h84, 32'hE000_0084);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'hE000_0084, 1'b1);
      checkOutput("E_req_gnt_rv", instr_req_o, 32'd1);
      checkOutput("E_addr_gnt_rv", instr_addr_o, 32'h88);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("E_req_8c", instr_req_o, 32'd1);
      checkOutput("E_addr_8c", instr_addr_o, 32'h8C);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("E_req_max2", instr_req_o, 32'd0);
      expectPush(32'h88, 32'hE000_0088);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hE000_0088, 1'b1);
      expectPush(32'h8C, 32'hE000_008C);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hE000_008C, 1'b1);
      idleCycle();
      checkOutput("E_busy_done", busy_o, 32'd0);

      // Address wrap from the top word of the address space.
      doReset();
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("F_req_branch", instr_req_o, 32'd0);
      checkOutput("F_clear", fifo_clear_o, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("F_req_top", instr_req_o, 32'd1);
      checkOutput("F_addr_top", instr_addr_o, 32'hFFFF_FFFC);
      expectPush(32'hFFFF_FFFC, 32'hF0F0_F0F0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hF0F0_F0F0, 1'b1);
      checkOutput("F_addr_wrap", instr_addr_o, 32'h0000_0000);
      idleCycle();
      checkOutput("F_busy_done", busy_o, 32'd0);

      // Every expected push must have been seen by the monitor.
      idleCycle();
      checkOutput("leftover_expected", 32'(expAddrQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
